// File: rtl/stat_snapshot_reader.sv
// Copies one stream's 64 statistics words from the stat RAM into a shadow bank, then swaps
// banks so CPU reads always come from a complete, coherent snapshot.
module stat_snapshot_reader #(
  parameter int RD_LAT    = 1,
  parameter int NUM_WORDS = 64
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        snap_req,
  input  logic [3:0]  snap_stream,
  output logic        snap_busy,
  output logic        snap_done,
  output logic [3:0]  snap_stream_out,
  output logic [15:0] snap_seq,
  output logic        ram_rd,
  output logic [15:0] ram_addr,
  input  logic [31:0] ram_data,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_addr,
  output logic [31:0] cpu_data,
  output logic        cpu_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  s_lat_q, s_lat_d;
  logic [5:0]  w_q, w_d;
  logic        ram_rd_q, ram_rd_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  stream_out_q, stream_out_d;
  logic [15:0] seq_q, seq_d;
  logic        bank_sel_q, bank_sel_d;
  logic        cpu_valid_q, cpu_valid_d;
  logic [31:0] cpu_data_q, cpu_data_d;

  // Capture pipeline: tracks which word the RAM is returning RD_LAT cycles after each read.
  logic [RD_LAT-1:0] pipe_v_q, pipe_v_d;
  logic [5:0]        pipe_w_q [RD_LAT];
  logic [5:0]        pipe_w_d [RD_LAT];
  logic              cap_v;
  logic [5:0]        cap_w;

  logic [31:0] bank_rd [2][NUM_WORDS];
  logic [1:0]  unused_addr_bits;

  assign cap_v = pipe_v_q[RD_LAT-1];
  assign cap_w = pipe_w_q[RD_LAT-1];
  assign unused_addr_bits = cpu_addr[1:0];

  always_comb begin
    pipe_v_d[0] = ram_rd_q;
    pipe_w_d[0] = ram_addr_q[7:2];
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
      pipe_w_d[i] = pipe_w_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_w_q[i] <= '0;
    end else begin
      pipe_v_q <= pipe_v_d;
      for (int i = 0; i < RD_LAT; i++) pipe_w_q[i] <= pipe_w_d[i];
    end
  end

  // Each bank word is its own flop so both banks clear in one cycle on reset.
  for (genvar gb = 0; gb < 2; gb++) begin : g_bank
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      logic [31:0] word_q, word_d;

      always_comb begin
        word_d = word_q;
        if (cap_v && (cap_w == 6'(gi)) && (bank_sel_q != 1'(gb)))
          word_d = ram_data;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) word_q <= '0;
        else     word_q <= word_d;
      end

      assign bank_rd[gb][gi] = word_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    s_lat_d      = s_lat_q;
    w_d          = w_q;
    ram_rd_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    stream_out_d = stream_out_q;
    seq_d        = seq_q;
    bank_sel_d   = bank_sel_q;
    case (state_q)
      IDLE: begin
        if (snap_req) begin
          s_lat_d    = snap_stream;
          w_d        = 6'd0;
          ram_rd_d   = 1'b1;
          ram_addr_d = {4'b0, snap_stream, 6'd0, 2'b00};
          busy_d     = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (w_q == 6'd63) begin
          state_d = DRAIN;
        end else begin
          w_d        = w_q + 6'd1;
          ram_rd_d   = 1'b1;
          ram_addr_d = {4'b0, s_lat_q, w_q + 6'd1, 2'b00};
        end
      end
      DRAIN: begin
        if (cap_v && (cap_w == 6'd63)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        // Swap on the edge leaving DONE so a read sampled in DONE still sees the old bank.
        bank_sel_d   = ~bank_sel_q;
        stream_out_d = s_lat_q;
        seq_d        = seq_q + 16'd1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_valid_d = cpu_rd;
    cpu_data_d  = cpu_data_q;
    if (cpu_rd) cpu_data_d = bank_rd[bank_sel_q][cpu_addr[7:2]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      s_lat_q      <= '0;
      w_q          <= '0;
      ram_rd_q     <= 1'b0;
      ram_addr_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      stream_out_q <= '0;
      seq_q        <= '0;
      bank_sel_q   <= 1'b0;
      cpu_valid_q  <= 1'b0;
      cpu_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      s_lat_q      <= s_lat_d;
      w_q          <= w_d;
      ram_rd_q     <= ram_rd_d;
      ram_addr_q   <= ram_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      stream_out_q <= stream_out_d;
      seq_q        <= seq_d;
      bank_sel_q   <= bank_sel_d;
      cpu_valid_q  <= cpu_valid_d;
      cpu_data_q   <= cpu_data_d;
    end
  end

  assign snap_busy       = busy_q;
  assign snap_done       = done_q;
  assign snap_stream_out = stream_out_q;
  assign snap_seq        = seq_q;
  assign ram_rd          = ram_rd_q;
  assign ram_addr        = ram_addr_q;
  assign cpu_valid       = cpu_valid_q;
  assign cpu_data        = cpu_data_q;

endmodule

// File: tb/tb_stat_snapshot_reader.sv
// Directed bench for stat_snapshot_reader: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3,
// each fed by its own RAM model returning 5A000000 | stream<<8 | word.
module tb_stat_snapshot_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snap_req [2];
  logic [3:0]  snap_stream [2];
  logic        cpu_rd;
  logic [7:0]  cpu_addr;
  logic        snap_busy [2];
  logic        snap_done [2];
  logic [3:0]  snap_stream_out [2];
  logic [15:0] snap_seq [2];
  logic        ram_rd [2];
  logic [15:0] ram_addr [2];
  logic [31:0] ram_data [2];
  logic [31:0] cpu_data [2];
  logic        cpu_valid [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stat_snapshot_reader #(.RD_LAT(1)) dut1 (
    .rst(rst), .clk(clk), .snap_req(snap_req[0]), .snap_stream(snap_stream[0]),
    .snap_busy(snap_busy[0]), .snap_done(snap_done[0]), .snap_stream_out(snap_stream_out[0]),
    .snap_seq(snap_seq[0]), .ram_rd(ram_rd[0]), .ram_addr(ram_addr[0]), .ram_data(ram_data[0]),
    .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_data(cpu_data[0]), .cpu_valid(cpu_valid[0])
  );

  stat_snapshot_reader #(.RD_LAT(3)) dut3 (
    .rst(rst), .clk(clk), .snap_req(snap_req[1]), .snap_stream(snap_stream[1]),
    .snap_busy(snap_busy[1]), .snap_done(snap_done[1]), .snap_stream_out(snap_stream_out[1]),
    .snap_seq(snap_seq[1]), .ram_rd(ram_rd[1]), .ram_addr(ram_addr[1]), .ram_data(ram_data[1]),
    .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_data(cpu_data[1]), .cpu_valid(cpu_valid[1])
  );

  function automatic logic [31:0] ram_word(input logic [15:0] a);
    return 32'h5A000000 | {20'd0, a[11:8], 2'b00, a[7:2]};
  endfunction

  logic [31:0] rpipe1;
  logic [31:0] rpipe3 [3];
  always @(posedge clk) begin
    rpipe1    <= ram_word(ram_addr[0]);
    rpipe3[0] <= ram_word(ram_addr[1]);
    rpipe3[1] <= rpipe3[0];
    rpipe3[2] <= rpipe3[1];
  end
  assign ram_data[0] = rpipe1;
  assign ram_data[1] = rpipe3[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("  ok   %s: %h", name, act);
    end
  endtask

  // Called at a negedge; returns at the negedge where the read data is due.
  task automatic cpu_read(input int k, input logic [7:0] a, input string name,
                          input logic [31:0] exp);
    cpu_rd   = 1'b1;
    cpu_addr = a;
    @(negedge clk);
    cpu_rd = 1'b0;
    chk({name, " valid"}, 32'(cpu_valid[k]), 32'd1);
    chk(name, cpu_data[k], exp);
  endtask

  task automatic run_snap(input int k, input logic [3:0] s, input int lat);
    int nrd, last, done_at, addr_err;
    logic [15:0] exp_a;
    nrd = 0; last = -1; done_at = -1; addr_err = 0;
    exp_a = {4'b0, s, 8'h00};
    snap_stream[k] = s;
    snap_req[k]    = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      snap_req[k] = 1'b0;
      if (i == 0) chk("busy after request", 32'(snap_busy[k]), 32'd1);
      if (ram_rd[k]) begin
        if (ram_addr[k] !== exp_a) addr_err++;
        exp_a = exp_a + 16'd4;
        nrd++;
        last = i;
      end
      if (snap_done[k]) begin
        done_at = i;
        break;
      end
    end
    chk("snap_done seen", 32'(done_at >= 0), 32'd1);
    chk("ram_rd burst length", 32'(nrd), 32'd64);
    chk("ram_addr sequence errors", 32'(addr_err), 32'd0);
    chk("done minus last ram_rd", 32'(done_at - last), 32'(lat + 1));
    chk("busy low in DONE", 32'(snap_busy[k]), 32'd0);
    @(negedge clk);
    chk("snap_done one cycle", 32'(snap_done[k]), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t s3_tab [6];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, bad, extra;
    logic seen;

    s3_tab[0] = '{8'h00, 32'h5A000300};
    s3_tab[1] = '{8'h14, 32'h5A000305};
    s3_tab[2] = '{8'h17, 32'h5A000305};
    s3_tab[3] = '{8'h0C, 32'h5A000303};
    s3_tab[4] = '{8'h80, 32'h5A000320};
    s3_tab[5] = '{8'hFC, 32'h5A00033F};

    snap_req[0] = 1'b0; snap_req[1] = 1'b0;
    snap_stream[0] = 4'd0; snap_stream[1] = 4'd0;
    cpu_rd = 1'b0; cpu_addr = 8'h00;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset snap_seq", 32'(snap_seq[0]), 32'd0);
    chk("reset snap_stream_out", 32'(snap_stream_out[0]), 32'd0);
    chk("reset snap_busy", 32'(snap_busy[0]), 32'd0);
    chk("reset ram_rd", 32'(ram_rd[0]), 32'd0);
    chk("reset cpu_valid", 32'(cpu_valid[0]), 32'd0);
    cpu_read(0, 8'h00, "reset read 0x00", 32'd0);
    cpu_read(0, 8'hFC, "reset read 0xFC", 32'd0);

    // Stream 3 snapshot, RD_LAT=1, then table-driven readback.
    run_snap(0, 4'd3, 1);
    chk("s3 snap_seq", 32'(snap_seq[0]), 32'd1);
    chk("s3 snap_stream_out", 32'(snap_stream_out[0]), 32'd3);
    for (int i = 0; i < 6; i++)
      cpu_read(0, s3_tab[i].addr, $sformatf("s3 read 0x%02h", s3_tab[i].addr), s3_tab[i].exp);
    @(negedge clk);
    chk("cpu_valid idle", 32'(cpu_valid[0]), 32'd0);
    chk("cpu_data holds", cpu_data[0], 32'h5A00033F);

    // Stream 7 with a read of 0x14 every cycle: old data through the DONE-cycle read.
    cpu_addr = 8'h14; cpu_rd = 1'b1;
    snap_stream[0] = 4'd7; snap_req[0] = 1'b1;
    bad = 0; seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      snap_req[0] = 1'b0;
      if (!cpu_valid[0] || cpu_data[0] !== 32'h5A000305) bad++;
      if (snap_done[0]) seen = 1'b1;
    end
    chk("s7 done seen", 32'(seen), 32'd1);
    chk("s7 reads before swap wrong", 32'(bad), 32'd0);
    @(negedge clk);
    chk("s7 read in DONE cycle", cpu_data[0], 32'h5A000305);
    @(negedge clk);
    chk("s7 read after swap", cpu_data[0], 32'h5A000705);
    cpu_rd = 1'b0;
    chk("s7 snap_seq", 32'(snap_seq[0]), 32'd2);
    chk("s7 snap_stream_out", 32'(snap_stream_out[0]), 32'd7);

    // Request held high: back-to-back snapshots with one IDLE cycle between.
    snap_stream[0] = 4'd2; snap_req[0] = 1'b1;
    t = 0;
    while (!snap_done[0] && t < 300) begin @(negedge clk); t++; end
    chk("held first done", 32'(snap_done[0]), 32'd1);
    @(negedge clk);
    chk("held idle gap ram_rd", 32'(ram_rd[0]), 32'd0);
    chk("held idle gap busy", 32'(snap_busy[0]), 32'd0);
    chk("held seq after first", 32'(snap_seq[0]), 32'd3);
    @(negedge clk);
    chk("held restart after one idle", 32'(ram_rd[0]), 32'd1);
    snap_req[0] = 1'b0;
    t = 0;
    while (!snap_done[0] && t < 300) begin @(negedge clk); t++; end
    chk("held second done", 32'(snap_done[0]), 32'd1);
    @(negedge clk);
    chk("held seq after second", 32'(snap_seq[0]), 32'd4);
    extra = 0;
    repeat (150) begin
      @(negedge clk);
      if (ram_rd[0] || snap_done[0]) extra++;
    end
    chk("no third snapshot", 32'(extra), 32'd0);

    // Reset in the middle of the burst, at word 20.
    snap_stream[0] = 4'd5; snap_req[0] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      snap_req[0] = 1'b0;
      t++;
    end while (!(ram_rd[0] && ram_addr[0][7:2] == 6'd20) && t < 100);
    chk("reached word 20", 32'(ram_addr[0]), 32'h0550);
    rst = 1'b1;
    #1;
    chk("abort ram_rd", 32'(ram_rd[0]), 32'd0);
    chk("abort busy", 32'(snap_busy[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (100) begin
      @(negedge clk);
      if (snap_done[0] || ram_rd[0]) extra++;
    end
    chk("abort no activity", 32'(extra), 32'd0);
    chk("abort snap_seq", 32'(snap_seq[0]), 32'd0);
    chk("abort snap_stream_out", 32'(snap_stream_out[0]), 32'd0);
    cpu_read(0, 8'h14, "abort read 0x14", 32'd0);
    cpu_read(0, 8'h50, "abort read 0x50", 32'd0);
    run_snap(0, 4'd3, 1);
    cpu_read(0, 8'h14, "post-abort read 0x14", 32'h5A000305);
    chk("post-abort snap_seq", 32'(snap_seq[0]), 32'd1);

    // RD_LAT=3 instance: same contents, done four cycles after the last read.
    run_snap(1, 4'd3, 3);
    chk("lat3 snap_seq", 32'(snap_seq[1]), 32'd1);
    chk("lat3 snap_stream_out", 32'(snap_stream_out[1]), 32'd3);
    for (int i = 0; i < 6; i++)
      cpu_read(1, s3_tab[i].addr, $sformatf("lat3 read 0x%02h", s3_tab[i].addr), s3_tab[i].exp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
